// File: rtl/seq_mult_approx.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : seq_mult_approx                                             |
// | Purpose  : Iterative shift-add WIDTH x WIDTH multiplier with optional  |
// |            two's-complement mode and compile-time truncation of the    |
// |            TRUNC least-significant partial-product columns.            |
// | Ports    : clk, rst_n (async, active-low), clear (sync abort)          |
// |            in_valid/in_ready, in_a, in_b, in_signed  - operand side    |
// |            out_valid/out_ready, out_p                - result side     |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module seq_mult_approx #(
  parameter int WIDTH = 8,
  parameter int TRUNC = 0
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               clear,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [WIDTH-1:0]   in_a,
  input  logic [WIDTH-1:0]   in_b,
  input  logic               in_signed,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [2*WIDTH-1:0] out_p
);

  localparam int P  = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
  // Columns below TRUNC never contribute to the accumulator.
  localparam logic [P-1:0] KEEP_MASK = {P{1'b1}} << TRUNC;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t          state;
  logic [P-1:0]    mcand_sh;   // multiplicand magnitude, shifted left each step
  logic [WIDTH-1:0] mplier_sh; // multiplier magnitude, shifted right each step
  logic            neg;
  logic [P-1:0]    acc;
  logic [CW-1:0]   cnt;

  logic [WIDTH-1:0] abs_a;
  logic [WIDTH-1:0] abs_b;
  logic [P-1:0]     term;
  logic [P-1:0]     acc_next;
  logic [P-1:0]     prod;

  // Two's-complement magnitude; the most negative value maps to 2^(WIDTH-1),
  // which still fits as an unsigned WIDTH-bit number.
  assign abs_a = (in_signed && in_a[WIDTH-1]) ? (~in_a + WIDTH'(1)) : in_a;
  assign abs_b = (in_signed && in_b[WIDTH-1]) ? (~in_b + WIDTH'(1)) : in_b;

  // mcand_sh already holds (multiplicand << counter), so masking it directly
  // drops the truncated columns of this row.
  assign term     = mplier_sh[0] ? (mcand_sh & KEEP_MASK) : '0;
  assign acc_next = acc + term;
  // Negating a zero magnitude yields zero, so signed zero comes out as 0.
  assign prod     = neg ? (~acc_next + P'(1)) : acc_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      out_p     <= '0;
      acc       <= '0;
      cnt       <= '0;
      mcand_sh  <= '0;
      mplier_sh <= '0;
      neg       <= 1'b0;
    end else if (clear) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            mcand_sh  <= {{WIDTH{1'b0}}, abs_a};
            mplier_sh <= abs_b;
            neg       <= in_signed & (in_a[WIDTH-1] ^ in_b[WIDTH-1]);
            acc       <= '0;
            cnt       <= '0;
            in_ready  <= 1'b0;
            state     <= BUSY;
          end
        end
        BUSY: begin
          acc       <= acc_next;
          cnt       <= cnt + CW'(1);
          mcand_sh  <= mcand_sh << 1;
          mplier_sh <= mplier_sh >> 1;
          if (cnt == LAST) begin
            out_p     <= prod;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
            state     <= IDLE;
          end
        end
        default: begin
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_mult_approx.sv
`default_nettype none
`timescale 1ns/1ps
// +------------------------------------------------------------------------+
// | Module   : tb_seq_mult_approx                                          |
// | Purpose  : Self-checking bench for seq_mult_approx. Several width /    |
// |            truncation configurations share one stimulus bus and run   |
// |            operations in lockstep; results are compared with an        |
// |            arithmetic reference model and a table of known products.  |
// | Revision : 1.0 - initial release                                       |
// +------------------------------------------------------------------------+
module tb_seq_mult_approx;

  localparam int NC = 10;

  function automatic int cfg_w(input int i);
    case (i)
      0, 1, 5, 6: cfg_w = 8;
      2, 3, 4:    cfg_w = 4;
      default:    cfg_w = 13;
    endcase
  endfunction

  function automatic int cfg_t(input int i);
    case (i)
      0, 2, 7: cfg_t = 0;
      1:       cfg_t = 4;
      3, 5, 8: cfg_t = 3;
      4:       cfg_t = 4;
      6:       cfg_t = 8;
      default: cfg_t = 13;
    endcase
  endfunction

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clear = 1'b0;
  logic        in_valid = 1'b0;
  logic [12:0] in_a = '0;
  logic [12:0] in_b = '0;
  logic        in_signed = 1'b0;
  logic        out_ready = 1'b0;
  logic [NC-1:0] rdy;
  logic [NC-1:0] ov;
  logic [25:0] pw  [NC];
  logic [25:0] res [NC];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NC; g++) begin : g_dut
    localparam int W = cfg_w(g);
    localparam int T = cfg_t(g);
    logic [2*W-1:0] p;
    seq_mult_approx #(.WIDTH(W), .TRUNC(T)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .clear     (clear),
      .in_valid  (in_valid),
      .in_ready  (rdy[g]),
      .in_a      (in_a[W-1:0]),
      .in_b      (in_b[W-1:0]),
      .in_signed (in_signed),
      .out_valid (ov[g]),
      .out_ready (out_ready),
      .out_p     (p)
    );
    assign pw[g] = 26'(p);
  end

  // Reference: magnitudes, each multiplier row shifted and stripped of its
  // columns below t, summed; then negated modulo 2^(2w) when signs differ.
  function automatic longint model(input int w, input int t, input longint a_in,
                                   input longint b_in, input bit sg);
    longint a, b, ma, mb, m, row, full;
    bit neg;
    full = longint'(1) << w;
    a = a_in & (full - 1);
    b = b_in & (full - 1);
    neg = 1'b0;
    ma = a;
    mb = b;
    if (sg) begin
      if (a >= full / 2) ma = full - a;
      if (b >= full / 2) mb = full - b;
      neg = (a >= full / 2) != (b >= full / 2);
    end
    m = 0;
    for (int j = 0; j < w; j++) begin
      if (((mb >> j) & 1) == 1) begin
        row = ma << j;
        m += row - (row % (longint'(1) << t));
      end
    end
    if (neg) m = ((longint'(1) << (2 * w)) - m) % (longint'(1) << (2 * w));
    return m;
  endfunction

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic wait_ov0(output bit ok);
    int k;
    k = 0;
    while (ov[0] !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    ok = (ov[0] === 1'b1);
  endtask

  // Lockstep operation on every instance: issue, wait for all results
  // (holding out_ready low as backpressure), snapshot, then release.
  task automatic do_op(input logic [12:0] a, input logic [12:0] b, input logic sg,
                       input int pre, input int stall, output int lat0, output bit rdy0_low);
    int k;
    repeat (pre) tick();
    k = 0;
    while (rdy !== {NC{1'b1}} && k < 100) begin
      tick();
      k++;
    end
    if (k >= 100) chk("ready_timeout", 0, 1);
    in_a = a;
    in_b = b;
    in_signed = sg;
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    in_a = 13'($urandom);
    in_b = 13'($urandom);
    in_signed = 1'($urandom);
    lat0 = 0;
    rdy0_low = 1'b1;
    k = 0;
    while (ov !== {NC{1'b1}} && k < 100) begin
      if (rdy[0] !== 1'b0) rdy0_low = 1'b0;
      tick();
      k++;
      if (ov[0] === 1'b1 && lat0 == 0) lat0 = k;
    end
    if (k >= 100) chk("valid_timeout", 0, 1);
    repeat (stall) begin
      if (rdy[0] !== 1'b0) rdy0_low = 1'b0;
      tick();
    end
    for (int g = 0; g < NC; g++) res[g] = pw[g];
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  typedef struct {
    string       name;
    int          cfg;
    logic [12:0] a;
    logic [12:0] b;
    logic        sg;
    longint      exp;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int  lat;
    bit  r0low, ok, stable, never;
    logic [25:0] p0;
    logic [12:0] ra, rb;
    logic rs;

    vecs[0]  = '{"u255x255",   0, 13'hFF, 13'hFF, 1'b0, 64'hFE01};
    vecs[1]  = '{"s-128x-128", 0, 13'h80, 13'h80, 1'b1, 64'h4000};
    vecs[2]  = '{"s-1x1",      0, 13'hFF, 13'h01, 1'b1, 64'hFFFF};
    vecs[3]  = '{"s-128x127",  0, 13'h80, 13'h7F, 1'b1, 64'hC080};
    vecs[4]  = '{"u80x7F",     0, 13'h80, 13'h7F, 1'b0, 64'h3F80};
    vecs[5]  = '{"u15x15",     0, 13'h0F, 13'h0F, 1'b0, 64'h00E1};
    vecs[6]  = '{"t4_u15x15",  1, 13'h0F, 13'h0F, 1'b0, 64'h00B0};
    vecs[7]  = '{"t4_s-15x15", 1, 13'hF1, 13'h0F, 1'b1, 64'hFF50};
    vecs[8]  = '{"w4_s-8x-8",  2, 13'h08, 13'h08, 1'b1, 64'h0040};
    vecs[9]  = '{"w4t4_15x15", 4, 13'h0F, 13'h0F, 1'b0, 64'h00B0};
    vecs[10] = '{"t8_u255x255", 6, 13'hFF, 13'hFF, 1'b0, 64'hF700};
    vecs[11] = '{"s0x-5",      0, 13'h00, 13'hFB, 1'b1, 64'h0000};

    // Reset state
    repeat (3) tick();
    chk("reset_in_ready", rdy[0], 1);
    chk("reset_out_valid", ov[0], 0);
    chk("reset_out_p", pw[0], 0);
    rst_n = 1'b1;
    tick();

    // Table-driven known products
    for (int i = 0; i < 12; i++) begin
      pulse_clear();
      do_op(vecs[i].a, vecs[i].b, vecs[i].sg, 0, 1, lat, r0low);
      chk(vecs[i].name, res[vecs[i].cfg], vecs[i].exp);
      if (i == 0) begin
        chk("latency_w8", lat, 8);
        chk("in_ready_low_busy_done", r0low, 1);
      end
    end

    // Backpressure: result held for 5 cycles, new op accepted one cycle late
    pulse_clear();
    in_a = 13'hFF; in_b = 13'hFF; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    wait_ov0(ok);
    chk("bp_valid_seen", ok, 1);
    p0 = pw[0];
    stable = 1'b1;
    repeat (5) begin
      tick();
      if (ov[0] !== 1'b1 || pw[0] !== p0 || rdy[0] !== 1'b0) stable = 1'b0;
    end
    chk("bp_stable", stable, 1);
    chk("bp_value", p0, 64'hFE01);
    out_ready = 1'b1; in_valid = 1'b1; in_a = 13'd3; in_b = 13'd4;
    tick();
    out_ready = 1'b0;
    chk("bp_not_accepted_ready", rdy[0], 1);
    chk("bp_valid_dropped", ov[0], 0);
    tick();
    in_valid = 1'b0;
    chk("bp_accepted_next", rdy[0], 0);
    wait_ov0(ok);
    chk("bp_next_result", pw[0], 12);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // Asynchronous reset in the middle of BUSY (counter = 3)
    pulse_clear();
    in_a = 13'h5A; in_b = 13'h3C; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (3) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_in_ready", rdy[0], 1);
    chk("arst_out_valid", ov[0], 0);
    chk("arst_out_p", pw[0], 0);
    @(negedge clk);
    rst_n = 1'b1;
    never = 1'b1;
    repeat (12) begin
      tick();
      if (ov[0] !== 1'b0) never = 1'b0;
    end
    chk("arst_no_result", never, 1);

    // Synchronous clear at counter = 5, then a normal operation
    in_a = 13'h55; in_b = 13'h33; in_signed = 1'b0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    repeat (5) tick();
    clear = 1'b1;
    tick();
    clear = 1'b0;
    chk("clear_in_ready", rdy[0], 1);
    never = (ov[0] === 1'b0);
    repeat (12) begin
      tick();
      if (ov[0] !== 1'b0) never = 1'b0;
    end
    chk("clear_no_result", never, 1);
    pulse_clear();
    do_op(13'd3, 13'd4, 1'b0, 0, 0, lat, r0low);
    chk("after_clear_3x4", res[0], 12);

    // Randomised operations across all configurations
    pulse_clear();
    for (int n = 0; n < 1500; n++) begin
      ra = 13'($urandom);
      rb = 13'($urandom);
      rs = 1'($urandom);
      do_op(ra, rb, rs, $urandom_range(0, 1), $urandom_range(0, 3), lat, r0low);
      for (int g = 0; g < NC; g++)
        chk($sformatf("rand_cfg%0d_a%0h_b%0h_s%0d", g, ra, rb, rs), res[g],
            model(cfg_w(g), cfg_t(g), longint'(ra), longint'(rb), rs));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
